// File: rtl/uart_rx_if.sv
// Serial receive link: line and frame options in, recovered byte and
// per-frame status strobes out. The receiver uses the slave view; the
// line driver / consumer uses the master view.
interface uart_rx_if;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stop_err;
  logic       busy;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, par_err, stop_err, busy
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, par_err, stop_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB-first, optional parity, stop.
// Line is oversampled PRESCALE clocks per bit; each bit is decided by a
// 2-of-3 majority around the bit centre. Results are one-cycle strobes.
module uart_rx #(
  parameter int PRESCALE = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] SMP_A    = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] SMP_B    = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] SMP_C    = CW'(PRESCALE / 2 + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   edge_cnt_q, edge_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [1:0]      smp_q, smp_d;
  logic            bit_q, bit_d;
  logic            par_en_q, par_en_d;
  logic            par_typ_q, par_typ_d;
  logic            par_bad_q, par_bad_d;
  logic [7:0]      pdata_q, pdata_d;
  logic            dv_q, dv_d;
  logic            pe_q, pe_d;
  logic            se_q, se_d;
  logic            rx_meta_q, rx_s_q;
  logic            bit_end;
  logic            bit_now;

  assign bit_end = (edge_cnt_q == CNT_LAST);
  // With the smallest prescale the third sample lands on the last tick,
  // so the vote is taken combinationally in that case.
  assign bit_now = (edge_cnt_q == SMP_C) ? maj3(smp_q[0], smp_q[1], rx_s_q) : bit_q;

  // Two-flop synchronizer for the asynchronous line, idling high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.RX_IN;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Control state, counters, latched frame options and result strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad_q  <= 1'b0;
      pdata_q    <= 8'h00;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_bad_q  <= par_bad_d;
      pdata_q    <= pdata_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  // Sample and shift registers; always rewritten before use in a frame.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    smp_q   <= smp_d;
    bit_q   <= bit_d;
  end

  // Next-state, sampling and frame-completion logic.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    smp_d      = smp_q;
    bit_d      = bit_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_bad_d  = par_bad_q;
    pdata_d    = pdata_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;

    if (state_q != S_IDLE) begin
      edge_cnt_d = bit_end ? '0 : edge_cnt_q + CW'(1);
      if (edge_cnt_q == SMP_A) smp_d[0] = rx_s_q;
      if (edge_cnt_q == SMP_B) smp_d[1] = rx_s_q;
      if (edge_cnt_q == SMP_C) bit_d    = maj3(smp_q[0], smp_q[1], rx_s_q);
    end

    case (state_q)
      S_IDLE: begin
        edge_cnt_d = '0;
        if (!rx_s_q) begin
          // Detect cycle counts as tick 0 of the start bit.
          state_d    = S_START;
          edge_cnt_d = CW'(1);
          par_en_d   = bus.PAR_EN;
          par_typ_d  = bus.PAR_TYP;
          par_bad_d  = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          if (bit_now) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d[bit_cnt_q] = bit_now;
          if (bit_cnt_q == 3'd7) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          par_bad_d = (bit_now != ((^shift_q) ^ par_typ_q));
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          se_d    = ~bit_now;
          pe_d    = par_bad_q;
          if (!par_bad_q && bit_now) begin
            dv_d    = 1'b1;
            pdata_d = shift_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.P_DATA     = pdata_q;
  assign bus.data_valid = dv_q;
  assign bus.par_err    = pe_q;
  assign bus.stop_err   = se_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, hand-written corner sequences
// (start glitch, sample glitch, mid-frame reset) and random frames checked
// against a frame-level reference model.
module tb_uart_rx;

  localparam int P = 8;

  typedef struct {
    logic [7:0] data;
    bit         par_en;
    bit         par_typ;
    bit         par_bit;
    bit         stop_bit;
    int         gap;
    bit         exp_dv;
    bit         exp_pe;
    bit         exp_se;
    logic [7:0] exp_pdata;
    int         exp_lat;
  } vec_t;

  typedef struct {
    int         cyc;
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] pdata;
    bit         busy;
    bit         busy_prev;
  } pulse_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;
  logic [7:0] mdl_pdata = 8'h00;

  pulse_t obs_q[$];
  pulse_t exp_q[$];
  pulse_t mon_p;
  bit     busy_prev_s = 1'b0;

  uart_rx_if bus();

  uart_rx #(.PRESCALE(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle in which any result strobe is high.
  always @(negedge clk) begin
    if (bus.data_valid || bus.par_err || bus.stop_err) begin
      mon_p.cyc       = cyc;
      mon_p.dv        = bus.data_valid;
      mon_p.pe        = bus.par_err;
      mon_p.se        = bus.stop_err;
      mon_p.pdata     = bus.P_DATA;
      mon_p.busy      = bus.busy;
      mon_p.busy_prev = busy_prev_s;
      obs_q.push_back(mon_p);
    end
    busy_prev_s = bus.busy;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference: parity and stop rules give the outcome, the
  // strobe cycle is pin fall + 2 synchronizer cycles + frame length.
  function automatic pulse_t model(input logic [7:0] d, input bit en, input bit typ,
                                   input bit pbit, input bit stop, input int fall);
    pulse_t r;
    int ones;
    bit want;
    ones  = $countones(d);
    want  = typ ? (ones % 2 == 0) : (ones % 2 == 1);
    r.pe  = en && (pbit != want);
    r.se  = !stop;
    r.dv  = !r.pe && !r.se;
    if (r.dv) mdl_pdata = d;
    r.pdata     = mdl_pdata;
    r.cyc       = fall + 2 + (en ? 11 : 10) * P;
    r.busy      = 1'b0;
    r.busy_prev = 1'b1;
    return r;
  endfunction

  function automatic bit good_parity(input logic [7:0] d, input bit typ);
    return typ ? ($countones(d) % 2 == 0) : ($countones(d) % 2 == 1);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.RX_IN = 1'b1;
    end
  endtask

  // Drive one frame; optionally flip the line for one cycle at (gbit, goff)
  // and scramble the frame-option inputs after the frame has started.
  task automatic send_frame(input logic [7:0] d, input bit en, input bit typ,
                            input bit pbit, input bit stop, input int gbit,
                            input int goff, input bit scramble, output int fall);
    logic bits[11];
    int   n;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    n = 9;
    if (en) begin
      bits[9] = pbit;
      n = 10;
    end
    bits[n] = stop;
    n++;
    fall = 0;
    for (int j = 0; j < n; j++) begin
      for (int t = 0; t < P; t++) begin
        @(posedge clk); #1;
        if (j == 0 && t == 0) begin
          bus.PAR_EN  = en;
          bus.PAR_TYP = typ;
          fall = cyc;
        end
        if (scramble && j == 3 && t == 0) begin
          bus.PAR_EN  = 1'($urandom);
          bus.PAR_TYP = 1'($urandom);
        end
        bus.RX_IN = bits[j] ^ ((j == gbit) && (t == goff));
      end
    end
  endtask

  task automatic drain(input string tag);
    int n;
    chk($sformatf("%s pulse count", tag), 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d] cycle", tag, i), 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
      chk($sformatf("%s[%0d] data_valid", tag, i), 32'(obs_q[i].dv), 32'(exp_q[i].dv));
      chk($sformatf("%s[%0d] par_err", tag, i), 32'(obs_q[i].pe), 32'(exp_q[i].pe));
      chk($sformatf("%s[%0d] stop_err", tag, i), 32'(obs_q[i].se), 32'(exp_q[i].se));
      chk($sformatf("%s[%0d] P_DATA", tag, i), 32'(obs_q[i].pdata), 32'(exp_q[i].pdata));
      chk($sformatf("%s[%0d] busy in pulse", tag, i), 32'(obs_q[i].busy), 32'(exp_q[i].busy));
      chk($sformatf("%s[%0d] busy before", tag, i), 32'(obs_q[i].busy_prev), 32'(exp_q[i].busy_prev));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vec_t   tbl[6];
    pulse_t e;
    int     fall, k, bc, b_start, b_end;
    logic   rbits[10];

    tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 8'hA5, 90};
    tbl[1] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0, 8'h5A, 90};
    tbl[2] = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'hC3, 90};
    tbl[3] = '{8'hB7, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 8'hB7, 82};
    tbl[4] = '{8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 4, 1'b0, 1'b1, 1'b0, 8'hB7, 90};
    tbl[5] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b1, 8'hB7, 90};

    bus.RX_IN   = 1'b1;
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset P_DATA", 32'(bus.P_DATA), 32'h00);
    chk("reset data_valid", 32'(bus.data_valid), 0);
    chk("reset par_err", 32'(bus.par_err), 0);
    chk("reset stop_err", 32'(bus.stop_err), 0);
    chk("reset busy", 32'(bus.busy), 0);
    idle(4);

    // Short start glitch: busy for one bit period minus the detect cycle.
    @(posedge clk); #1;
    bus.RX_IN = 1'b0;
    k = cyc;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.RX_IN = 1'b1;
    bc = 0; b_start = 0; b_end = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      if (cyc == k + 3) b_start = bus.busy;
      if (cyc == k + 2 + P) b_end = bus.busy;
    end
    chk("glitch busy cycles", 32'(bc), 32'(P - 1));
    chk("glitch busy at S+1", 32'(b_start), 1);
    chk("glitch busy at S+P", 32'(b_end), 0);
    drain("glitch_start");

    // One-cycle glitch on the centre sample of data bit 3 is voted out.
    send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 4, P / 2, 1'b0, fall);
    exp_q.push_back(model(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, fall));
    idle(6);
    drain("sample_glitch");

    // Directed frame table.
    for (int i = 0; i < 6; i++) begin
      idle(tbl[i].gap);
      send_frame(tbl[i].data, tbl[i].par_en, tbl[i].par_typ, tbl[i].par_bit,
                 tbl[i].stop_bit, -1, 0, 1'b0, fall);
      e.cyc = fall + tbl[i].exp_lat;
      e.dv = tbl[i].exp_dv;
      e.pe = tbl[i].exp_pe;
      e.se = tbl[i].exp_se;
      e.pdata = tbl[i].exp_pdata;
      e.busy = 1'b0;
      e.busy_prev = 1'b1;
      exp_q.push_back(e);
    end
    idle(6);
    if (obs_q.size() >= 3)
      chk("back-to-back spacing", 32'(obs_q[2].cyc - obs_q[1].cyc), 32'(11 * P));
    drain("table");

    // Reset during data bit 4 discards the frame.
    bus.PAR_EN = 1'b0;
    rbits[0] = 1'b0;
    for (int i = 0; i < 8; i++) rbits[i+1] = (i >= 4);
    rbits[9] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      for (int t = 0; t < P; t++) begin
        @(posedge clk); #1;
        bus.RX_IN = rbits[j];
        rst = (j == 5 && t == P / 2);
        if (j == 5 && t == P / 2) begin
          @(negedge clk);
          chk("busy before rst", 32'(bus.busy), 1);
        end
        if (j == 5 && t == P / 2 + 1) begin
          @(negedge clk);
          chk("post-rst busy", 32'(bus.busy), 0);
          chk("post-rst P_DATA", 32'(bus.P_DATA), 32'h00);
          chk("post-rst data_valid", 32'(bus.data_valid), 0);
          chk("post-rst par_err", 32'(bus.par_err), 0);
          chk("post-rst stop_err", 32'(bus.stop_err), 0);
        end
      end
    end
    mdl_pdata = 8'h00;
    idle(6);
    drain("mid_reset");

    send_frame(8'h81, 1'b1, 1'b1, 1'b1, 1'b1, -1, 0, 1'b0, fall);
    exp_q.push_back(model(8'h81, 1'b1, 1'b1, 1'b1, 1'b1, fall));
    idle(6);
    drain("after_reset");

    // Random frames with bad parity/stop, gaps (incl. none), sample
    // glitches and option inputs changing mid-frame.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      bit en, typ, pbit, stop;
      int gbit, goff;
      d    = 8'($urandom);
      en   = 1'($urandom_range(0, 1));
      typ  = 1'($urandom_range(0, 1));
      pbit = good_parity(d, typ) ^ ($urandom_range(0, 4) == 0);
      stop = ($urandom_range(0, 5) != 0);
      gbit = -1;
      goff = 0;
      if ($urandom_range(0, 1) == 1) begin
        gbit = $urandom_range(0, en ? 10 : 9);
        goff = P / 2 - 1 + $urandom_range(0, 2);
      end
      idle($urandom_range(0, 3));
      send_frame(d, en, typ, pbit, stop, gbit, goff, 1'b1, fall);
      exp_q.push_back(model(d, en, typ, pbit, stop, fall));
    end
    idle(6);
    drain("random");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
